receiver_uart: RTL and testbench
================================

# receiver_uart

UART byte receiver with a packet parser on top, sitting between a serial RXD pin and a small register file or RAM. It deserializes 8-bit UART characters and assembles them into packets of the form cmd, len, len data bytes, checksum. Data bytes go out through a RAM-style write port. A verified packet raises a one-cycle done strobe with the command and length latched.

## Interface
- CLOCK, 10_000_000: system clock frequency, Hz.
- BAUD, 1_000_000: line rate. FACTOR = CLOCK/BAUD, integer, ≥ 4, clocks per bit.
- PARITY, "NO": "ODD", "EVEN" or "NO". Selects whether a parity bit follows the data bits.
- FIRST_BIT, "LSB": "LSB" or "MSB", the serial bit order.
- NUMBER, 8: write-buffer depth, 2..256. AW = max(1, $clog2(NUMBER)).
- TIMEOUT, 2: maximum idle gap between bytes of one packet, in character times.
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- rxd, input, 1: serial line, idle high, asynchronous to clk.
- rx_done, output, 1: one-cycle strobe when a valid packet completes.
- cmd_rx, output, 8: command byte of the last valid packet.
- len_rx, output, 8: length byte of the last valid packet.
- wr_data, output, 8: data byte being written.
- wr_addr, output, AW: write address, equal to the data byte index.
- wr_clock, output, 1: write clock. It is clk forwarded directly.
- we, output, 1: write enable, one cycle per stored data byte.

## Operation
- rxd passes through a 2-FF synchronizer, preset to 1 on reset.
- Character receiver states: IDLE, START, BITS, PARITY, STOP.
  - IDLE: a synchronized falling edge enters START.
  - START: re-sample at FACTOR/2. If rxd is still 0, go to BITS; otherwise go back to IDLE.
  - BITS: sample 8 bits at FACTOR intervals, filling per FIRST_BIT.
  - PARITY: present only if PARITY ≠ "NO". EVEN requires the parity bit to equal ^data; ODD requires ~^data.
  - STOP: sample the stop bit.
- Character valid = stop bit 1 and parity OK. Otherwise it is an error.
- Packet parser states: CMD, LEN, DATA, SUM.
  - CMD: store cmd, set sum = cmd, go to LEN.
  - LEN: store len, sum += len. If len = 0, go to SUM; otherwise reset the index to 0 and go to DATA.
  - DATA: sum += byte. If index < NUMBER, pulse we with wr_addr = index[AW-1:0] and wr_data = byte. Bytes with index ≥ NUMBER are checked but not written. Increment index; after len bytes, go to SUM.
  - SUM: the packet is valid if byte == ~sum, using 8-bit wrap-around arithmetic. If valid, latch cmd_rx = cmd and len_rx = len, and pulse rx_done. Return to CMD in either case.
- Character error in any state: abort, return to CMD, no rx_done. Writes already issued stay.
- Timeout: in LEN, DATA or SUM, if the idle time since the last stop sample exceeds TIMEOUT × (10, or 11 with parity) × FACTOR clocks, return to CMD.

## Timing
- Reset values: rx_done = 0, cmd_rx = 0, len_rx = 0, wr_data = 0, wr_addr = 0, we = 0. Both FSMs reset to IDLE and CMD.
- Reset asserted mid-packet: the packet is discarded immediately.
- A character completes at the mid-stop-bit sample, t0.
- we and wr_data/wr_addr are registered, valid in cycle t0+1. wr_data/wr_addr hold until the next write.
- rx_done is high for cycle t0+1 of the checksum byte. cmd_rx and len_rx update in that same cycle and hold afterwards.
- A new start edge is accepted in the cycle after the stop sample, so back-to-back characters are supported.
- Timeout is measured from t0. A start edge arriving exactly at the limit is accepted.

## Configuration
- RECEIVER_UART_CHECKSUM_EN
  - Defined: the checksum is compared, and rx_done pulses only on a match.
  - Undefined: the SUM byte is consumed without comparison, and rx_done pulses for every packet completed without errors.

## Test plan
- Defaults, packet 53 05 D0 D1 D2 D3 D4 then ~(sum) at 1 Mbaud → we pulses at addr 0..4 with wr_data = D0..D4. rx_done pulses once; cmd_rx = 0x53, len_rx = 0x05.
- Same packet with the checksum XOR 0x01 → five writes, no rx_done, cmd_rx and len_rx unchanged. Repeat with the macro undefined → rx_done pulses.
- Packet 0x11 0x00 0xEE → no we, rx_done pulses, len_rx = 0.
- Packet len = 0x0A with NUMBER = 8 → writes only at addr 0..7. rx_done pulses if the checksum covers all 10 bytes.
- After cmd and len, idle for 3 character times, then send a new full packet 53 05 … → the first packet is abandoned and the second decodes correctly.
- PARITY = "ODD", FIRST_BIT = "MSB", one data byte sent with wrong parity → abort, no rx_done. A stop bit forced to 0 likewise aborts. Asserting reset mid-data clears all outputs to 0.

Source files
------------

// File: rtl/receiver_uart.sv
// receiver_uart
// UART character receiver with a packet parser on top. Characters are
// assembled into packets of the form: cmd, len, len data bytes, checksum.
// Data bytes go out through a RAM-style write port; a complete packet
// pulses rx_done with the command and length latched.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   rxd      in   serial line, idle high, asynchronous to clk
//   rx_done  out  one-cycle strobe when a packet completes
//   cmd_rx   out  command byte of the last completed packet
//   len_rx   out  length byte of the last completed packet
//   wr_data  out  data byte being written (holds until next write)
//   wr_addr  out  write address = data byte index (holds until next write)
//   wr_clock out  clk forwarded for the write port
//   we       out  write enable, one cycle per stored data byte
//
// Build option: define RECEIVER_UART_CHECKSUM_EN to compare the checksum
// byte against ~(cmd + len + data); when undefined the checksum byte is
// consumed without comparison.
module receiver_uart #(
    parameter int    CLOCK     = 10_000_000,
    parameter int    BAUD      = 1_000_000,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB",
    parameter int    NUMBER    = 8,
    parameter int    TIMEOUT   = 2,
    localparam int   AW        = (NUMBER <= 2) ? 1 : $clog2(NUMBER)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rxd,
    output logic          rx_done,
    output logic [7:0]    cmd_rx,
    output logic [7:0]    len_rx,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_clock,
    output logic          we
);

    localparam int FACTOR    = CLOCK / BAUD;
    localparam int HALF      = FACTOR / 2;
    localparam bit HAS_PAR   = (PARITY != "NO");
    localparam bit ODD_PAR   = (PARITY == "ODD");
    localparam bit MSB_FIRST = (FIRST_BIT == "MSB");
    localparam int CHAR_BITS = HAS_PAR ? 11 : 10;
    localparam int LIMIT     = TIMEOUT * CHAR_BITS * FACTOR;
    localparam int CW        = $clog2(FACTOR);
    localparam int TW        = $clog2(LIMIT + 1);

`ifdef RECEIVER_UART_CHECKSUM_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_BITS, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {PS_CMD, PS_LEN, PS_DATA, PS_SUM} ps_state_t;

    rx_state_t     r_rx_state;
    ps_state_t     r_ps;
    logic          r_rxd_s1, r_rxd_s2, r_rxd_d;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_par_ok;

    logic [7:0]    r_cmd, r_len, r_sum, r_idx;
    logic [TW-1:0] r_idle;
    logic          r_rx_done, r_we;
    logic [7:0]    r_cmd_rx, r_len_rx, r_wr_data;
    logic [AW-1:0] r_wr_addr;

    logic       w_fall, w_tick, w_stop, w_char_ok, w_char_err, w_tmo, w_sum_ok, w_par_exp;
    logic [7:0] w_shift_nxt;

    assign w_fall      = r_rxd_d & ~r_rxd_s2;
    assign w_tick      = (r_cnt == CW'(FACTOR - 1));
    assign w_stop      = (r_rx_state == RX_STOP) && w_tick;
    assign w_char_ok   = w_stop && r_rxd_s2 && r_par_ok;
    assign w_char_err  = w_stop && !(r_rxd_s2 && r_par_ok);
    assign w_par_exp   = ODD_PAR ? ~^r_shift : ^r_shift;
    assign w_shift_nxt = MSB_FIRST ? {r_shift[6:0], r_rxd_s2} : {r_rxd_s2, r_shift[7:1]};
    assign w_sum_ok    = !CHECK_EN || (r_shift == ~r_sum);
    // A start edge landing exactly on the limit wins over the timeout.
    assign w_tmo       = (r_ps != PS_CMD) && (r_rx_state == RX_IDLE) && !w_fall &&
                         (r_idle >= TW'(LIMIT));

    // Character receiver: synchronizer, start qualification, bit sampling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_d    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_ok   <= 1'b1;
        end else begin
            r_rxd_s1 <= rxd;
            r_rxd_s2 <= r_rxd_s1;
            r_rxd_d  <= r_rxd_s2;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_cnt      <= '0;
                        r_par_ok   <= 1'b1;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == CW'(HALF - 1)) begin
                        r_cnt      <= '0;
                        r_bit      <= '0;
                        r_rx_state <= r_rxd_s2 ? RX_IDLE : RX_BITS;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_BITS: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= w_shift_nxt;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            r_rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_PARITY: begin
                    if (w_tick) begin
                        r_cnt      <= '0;
                        r_par_ok   <= (r_rxd_s2 == w_par_exp);
                        r_rx_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        r_cnt      <= '0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Packet parser: acts on the character-complete pulse at the stop sample,
    // so its registered outputs appear in the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ps      <= PS_CMD;
            r_cmd     <= '0;
            r_len     <= '0;
            r_sum     <= '0;
            r_idx     <= '0;
            r_idle    <= '0;
            r_rx_done <= 1'b0;
            r_we      <= 1'b0;
            r_cmd_rx  <= '0;
            r_len_rx  <= '0;
            r_wr_data <= '0;
            r_wr_addr <= '0;
        end else begin
            r_rx_done <= 1'b0;
            r_we      <= 1'b0;
            // Idle time counts only while the line is between characters.
            if (w_stop)
                r_idle <= '0;
            else if (r_rx_state == RX_IDLE && r_idle < TW'(LIMIT))
                r_idle <= r_idle + TW'(1);

            if (w_char_err || w_tmo) begin
                r_ps <= PS_CMD;
            end else if (w_char_ok) begin
                case (r_ps)
                    PS_CMD: begin
                        r_cmd <= r_shift;
                        r_sum <= r_shift;
                        r_ps  <= PS_LEN;
                    end
                    PS_LEN: begin
                        r_len <= r_shift;
                        r_sum <= r_sum + r_shift;
                        r_idx <= '0;
                        r_ps  <= (r_shift == 8'd0) ? PS_SUM : PS_DATA;
                    end
                    PS_DATA: begin
                        r_sum <= r_sum + r_shift;
                        // Bytes beyond the buffer still count toward the checksum.
                        if ({1'b0, r_idx} < 9'(NUMBER)) begin
                            r_we      <= 1'b1;
                            r_wr_addr <= r_idx[AW-1:0];
                            r_wr_data <= r_shift;
                        end
                        r_idx <= r_idx + 8'd1;
                        if (r_idx == r_len - 8'd1)
                            r_ps <= PS_SUM;
                    end
                    PS_SUM: begin
                        if (w_sum_ok) begin
                            r_cmd_rx  <= r_cmd;
                            r_len_rx  <= r_len;
                            r_rx_done <= 1'b1;
                        end
                        r_ps <= PS_CMD;
                    end
                    default: r_ps <= PS_CMD;
                endcase
            end
        end
    end

    assign rx_done  = r_rx_done;
    assign cmd_rx   = r_cmd_rx;
    assign len_rx   = r_len_rx;
    assign wr_data  = r_wr_data;
    assign wr_addr  = r_wr_addr;
    assign we       = r_we;
    assign wr_clock = clk;

endmodule

// File: tb/tb_receiver_uart.sv
`timescale 1ns/1ps
module tb_receiver_uart;

    localparam int FACTOR = 10;
    localparam int NUM    = 8;
`ifdef RECEIVER_UART_CHECKSUM_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t [$];

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic       rx_done_a, we_a, wr_clock_a, rx_done_b, we_b, wr_clock_b;
    logic [7:0] cmd_rx_a, len_rx_a, wr_data_a, cmd_rx_b, len_rx_b, wr_data_b;
    logic [2:0] wr_addr_a, wr_addr_b;

    int checks = 0;
    int errors = 0;

    // Event = {dut, kind(0 write / 1 done), addr7, data/cmd, 0/len}
    logic [24:0] exp_q [$];
    logic [24:0] obs_q [$];
    logic [24:0] ew, ow;
    logic [7:0]  last_cmd_a = 8'h00, last_len_a = 8'h00;
    logic [7:0]  last_cmd_b = 8'h00, last_len_b = 8'h00;

    always #50 clk = ~clk;

    receiver_uart u_dut_a (
        .clk(clk), .reset(reset), .rxd(rxd_a),
        .rx_done(rx_done_a), .cmd_rx(cmd_rx_a), .len_rx(len_rx_a),
        .wr_data(wr_data_a), .wr_addr(wr_addr_a), .wr_clock(wr_clock_a), .we(we_a)
    );

    receiver_uart #(.PARITY("ODD"), .FIRST_BIT("MSB")) u_dut_b (
        .clk(clk), .reset(reset), .rxd(rxd_b),
        .rx_done(rx_done_b), .cmd_rx(cmd_rx_b), .len_rx(len_rx_b),
        .wr_data(wr_data_b), .wr_addr(wr_addr_b), .wr_clock(wr_clock_b), .we(we_b)
    );

    always @(negedge clk) begin
        if (we_a)      obs_q.push_back({1'b0, 1'b0, 4'h0, wr_addr_a, wr_data_a, 8'h00});
        if (rx_done_a) obs_q.push_back({1'b0, 1'b1, 7'h00, cmd_rx_a, len_rx_a});
        if (we_b)      obs_q.push_back({1'b1, 1'b0, 4'h0, wr_addr_b, wr_data_b, 8'h00});
        if (rx_done_b) obs_q.push_back({1'b1, 1'b1, 7'h00, cmd_rx_b, len_rx_b});
    end

    task automatic drive_bit(input bit which, input logic v);
        if (which) rxd_b = v; else rxd_a = v;
        repeat (FACTOR) @(negedge clk);
    endtask

    // DUT a: LSB first, no parity. DUT b: MSB first, odd parity.
    task automatic send_byte(input bit which, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, which ? b[7-i] : b[i]);
        if (which) drive_bit(which, (~^b) ^ bad_par);
        drive_bit(which, ~bad_stop);
        if (bad_stop) drive_bit(which, 1'b1);
    endtask

    task automatic send_pkt(input bit which, input logic [7:0] cmd, input bq_t d, input logic [7:0] chk_xor);
        logic [7:0] len, sum;
        len = 8'(d.size());
        sum = cmd + len;
        foreach (d[i]) begin
            sum = sum + d[i];
            if (i < NUM) exp_q.push_back({which, 1'b0, 7'(i), d[i], 8'h00});
        end
        if (chk_xor == 8'h00 || !CHECK_EN) begin
            exp_q.push_back({which, 1'b1, 7'h00, cmd, len});
            if (which) begin last_cmd_b = cmd; last_len_b = len; end
            else begin last_cmd_a = cmd; last_len_a = len; end
        end
        send_byte(which, cmd, 1'b0, 1'b0);
        send_byte(which, len, 1'b0, 1'b0);
        foreach (d[i]) send_byte(which, d[i], 1'b0, 1'b0);
        send_byte(which, ~sum ^ chk_xor, 1'b0, 1'b0);
        repeat (2 * FACTOR) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++;
        if ({rx_done_a, we_a, rx_done_b, we_b} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes got %b required 0000", {rx_done_a, we_a, rx_done_b, we_b});
        end
        checks++;
        if ({cmd_rx_a, len_rx_a, wr_data_a, wr_addr_a} !== 27'd0) begin
            errors++; $display("FAIL reset_outputs_a got %h required 0", {cmd_rx_a, len_rx_a, wr_data_a, wr_addr_a});
        end
        checks++;
        if ({cmd_rx_b, len_rx_b, wr_data_b, wr_addr_b} !== 27'd0) begin
            errors++; $display("FAIL reset_outputs_b got %h required 0", {cmd_rx_b, len_rx_b, wr_data_b, wr_addr_b});
        end
        reset = 1'b1;
        repeat (2 * FACTOR) @(negedge clk);
    endtask

    task automatic test_packet();
        bq_t d;
        for (int i = 0; i < 5; i++) d.push_back(8'hD0 + 8'(i));
        send_pkt(1'b0, 8'h53, d, 8'h00);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            ew = 'x; ow = 'x;
            if (exp_q.size() > 0) ew = exp_q.pop_front();
            if (obs_q.size() > 0) ow = obs_q.pop_front();
            checks++;
            if (ow !== ew) begin errors++; $display("FAIL packet_event got %h required %h", ow, ew); end
        end
        checks++;
        if ({cmd_rx_a, len_rx_a} !== 16'h5305) begin
            errors++; $display("FAIL packet_cmd_len got %h required 5305", {cmd_rx_a, len_rx_a});
        end
    endtask

    task automatic test_bad_checksum();
        bq_t d;
        for (int i = 0; i < 5; i++) d.push_back(8'hD0 + 8'(i));
        send_pkt(1'b0, 8'h44, d, 8'h01);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            ew = 'x; ow = 'x;
            if (exp_q.size() > 0) ew = exp_q.pop_front();
            if (obs_q.size() > 0) ow = obs_q.pop_front();
            checks++;
            if (ow !== ew) begin errors++; $display("FAIL badsum_event got %h required %h", ow, ew); end
        end
        checks++;
        if ({cmd_rx_a, len_rx_a} !== {last_cmd_a, last_len_a}) begin
            errors++; $display("FAIL badsum_cmd_len got %h required %h", {cmd_rx_a, len_rx_a}, {last_cmd_a, last_len_a});
        end
    endtask

    task automatic test_zero_len();
        bq_t d;
        send_pkt(1'b0, 8'h11, d, 8'h00);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            ew = 'x; ow = 'x;
            if (exp_q.size() > 0) ew = exp_q.pop_front();
            if (obs_q.size() > 0) ow = obs_q.pop_front();
            checks++;
            if (ow !== ew) begin errors++; $display("FAIL zerolen_event got %h required %h", ow, ew); end
        end
        checks++;
        if ({cmd_rx_a, len_rx_a} !== 16'h1100) begin
            errors++; $display("FAIL zerolen_cmd_len got %h required 1100", {cmd_rx_a, len_rx_a});
        end
    endtask

    task automatic test_overflow();
        bq_t d;
        for (int i = 0; i < 10; i++) d.push_back(8'(i * 7 + 1));
        send_pkt(1'b0, 8'h2A, d, 8'h00);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            ew = 'x; ow = 'x;
            if (exp_q.size() > 0) ew = exp_q.pop_front();
            if (obs_q.size() > 0) ow = obs_q.pop_front();
            checks++;
            if (ow !== ew) begin errors++; $display("FAIL overflow_event got %h required %h", ow, ew); end
        end
        checks++;
        if ({cmd_rx_a, len_rx_a} !== 16'h2A0A) begin
            errors++; $display("FAIL overflow_cmd_len got %h required 2a0a", {cmd_rx_a, len_rx_a});
        end
    endtask

    task automatic test_timeout();
        bq_t d;
        send_byte(1'b0, 8'h53, 1'b0, 1'b0);
        send_byte(1'b0, 8'h05, 1'b0, 1'b0);
        repeat (30 * FACTOR) @(negedge clk);
        for (int i = 0; i < 5; i++) d.push_back(8'hB0 + 8'(i));
        send_pkt(1'b0, 8'h53, d, 8'h00);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            ew = 'x; ow = 'x;
            if (exp_q.size() > 0) ew = exp_q.pop_front();
            if (obs_q.size() > 0) ow = obs_q.pop_front();
            checks++;
            if (ow !== ew) begin errors++; $display("FAIL timeout_event got %h required %h", ow, ew); end
        end
    endtask

    task automatic test_parity_stop();
        bq_t d;
        d.push_back(8'h3C);
        send_pkt(1'b1, 8'hA5, d, 8'h00);
        send_byte(1'b1, 8'h5A, 1'b0, 1'b0);
        send_byte(1'b1, 8'h01, 1'b0, 1'b0);
        send_byte(1'b1, 8'h77, 1'b1, 1'b0);
        send_byte(1'b1, 8'h66, 1'b0, 1'b0);
        send_byte(1'b1, 8'h02, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 7'h00, 8'h10, 8'h00});
        send_byte(1'b1, 8'h10, 1'b0, 1'b0);
        send_byte(1'b1, 8'h20, 1'b0, 1'b1);
        repeat (2 * FACTOR) @(negedge clk);
        checks++;
        if ({cmd_rx_b, len_rx_b} !== 16'hA501) begin
            errors++; $display("FAIL parity_abort_cmd_len got %h required a501", {cmd_rx_b, len_rx_b});
        end
        d.delete();
        d.push_back(8'h44);
        d.push_back(8'h55);
        send_pkt(1'b1, 8'hC3, d, 8'h00);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            ew = 'x; ow = 'x;
            if (exp_q.size() > 0) ew = exp_q.pop_front();
            if (obs_q.size() > 0) ow = obs_q.pop_front();
            checks++;
            if (ow !== ew) begin errors++; $display("FAIL parity_event got %h required %h", ow, ew); end
        end
        checks++;
        if ({cmd_rx_b, len_rx_b} !== 16'hC302) begin
            errors++; $display("FAIL parity_cmd_len got %h required c302", {cmd_rx_b, len_rx_b});
        end
    endtask

    task automatic test_reset_mid();
        bq_t d;
        send_byte(1'b0, 8'h53, 1'b0, 1'b0);
        send_byte(1'b0, 8'h03, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 7'h00, 8'hAB, 8'h00});
        send_byte(1'b0, 8'hAB, 1'b0, 1'b0);
        rxd_a = 1'b0;
        repeat (3 * FACTOR) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_done_a, we_a, cmd_rx_a, len_rx_a, wr_data_a, wr_addr_a} !== 29'd0) begin
            errors++; $display("FAIL midreset_outputs got %h required 0", {rx_done_a, we_a, cmd_rx_a, len_rx_a, wr_data_a, wr_addr_a});
        end
        rxd_a = 1'b1;
        repeat (2 * FACTOR) @(negedge clk);
        reset = 1'b1;
        repeat (2 * FACTOR) @(negedge clk);
        d.push_back(8'h01);
        send_pkt(1'b0, 8'h7E, d, 8'h00);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            ew = 'x; ow = 'x;
            if (exp_q.size() > 0) ew = exp_q.pop_front();
            if (obs_q.size() > 0) ow = obs_q.pop_front();
            checks++;
            if (ow !== ew) begin errors++; $display("FAIL midreset_event got %h required %h", ow, ew); end
        end
        checks++;
        if ({cmd_rx_a, len_rx_a} !== 16'h7E01) begin
            errors++; $display("FAIL midreset_cmd_len got %h required 7e01", {cmd_rx_a, len_rx_a});
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog got no finish required finish within 10 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_packet();
        test_bad_checksum();
        test_zero_len();
        test_overflow();
        test_timeout();
        test_parity_stop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
